// File: rtl/led_pwm_ctrl_if.sv
// Configuration and readback bundle between the register file (master) and
// the LED PWM controller (slave).
interface led_pwm_ctrl_if #(
  parameter int NLED       = 4,
  parameter int PRESCALE_W = 16
);
  logic [2*NLED-1:0]     cfg_mode;
  logic [8*NLED-1:0]     cfg_duty;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic [15:0]           cfg_blink_half;
  logic                  cfg_load;
  logic [NLED-1:0]       led;
  logic [31:0]           status;

  modport master (
    output cfg_mode, cfg_duty, cfg_prescale, cfg_blink_half, cfg_load,
    input  led, status
  );

  modport slave (
    input  cfg_mode, cfg_duty, cfg_prescale, cfg_blink_half, cfg_load,
    output led, status
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM controller with OFF/ON/BLINK/BREATHE modes; register
// writes are shadowed and take effect only at a PWM frame boundary.
module led_pwm_ctrl #(
  parameter int NLED       = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic           axi_aclk,
  input  logic           axi_areset,
  led_pwm_ctrl_if.slave  bus
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

  logic [2*NLED-1:0]     shd_mode_q, shd_mode_d, act_mode_q, act_mode_d, eff_mode;
  logic [8*NLED-1:0]     shd_duty_q, shd_duty_d, act_duty_q, act_duty_d, eff_duty;
  logic [PRESCALE_W-1:0] shd_presc_q, shd_presc_d, act_presc_q, act_presc_d, eff_presc;
  logic [15:0]           shd_blink_q, shd_blink_d, act_blink_q, act_blink_d, eff_blink;
  logic                  pending_q, pending_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [15:0]           blink_cnt_q, blink_cnt_d, blink_lim;
  logic                  phase_q, phase_d;
  logic [NLED-1:0]       led_q, led_d;
  logic [7:0]            led0_level;
  logic                  led0_down;
  logic                  tick, boundary, apply;

  function automatic logic pwm_on(input logic [7:0] x, input logic [7:0] cnt);
    return (x == 8'hFF) || (cnt < x);
  endfunction

  assign tick     = (presc_cnt_q == act_presc_q);
  assign boundary = tick && (pwm_cnt_q == 8'hFF);
  assign apply    = boundary && (pending_q || bus.cfg_load);

  // A write landing exactly on the boundary bypasses the shadow registers.
  assign eff_mode  = bus.cfg_load ? bus.cfg_mode       : shd_mode_q;
  assign eff_duty  = bus.cfg_load ? bus.cfg_duty       : shd_duty_q;
  assign eff_presc = bus.cfg_load ? bus.cfg_prescale   : shd_presc_q;
  assign eff_blink = bus.cfg_load ? bus.cfg_blink_half : shd_blink_q;

  assign blink_lim = (act_blink_q == 16'd0) ? 16'd0 : act_blink_q - 16'd1;

  always_comb begin
    shd_mode_d  = shd_mode_q;
    shd_duty_d  = shd_duty_q;
    shd_presc_d = shd_presc_q;
    shd_blink_d = shd_blink_q;
    act_mode_d  = act_mode_q;
    act_duty_d  = act_duty_q;
    act_presc_d = act_presc_q;
    act_blink_d = act_blink_q;
    pending_d   = pending_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

    if (bus.cfg_load) begin
      shd_mode_d  = bus.cfg_mode;
      shd_duty_d  = bus.cfg_duty;
      shd_presc_d = bus.cfg_prescale;
      shd_blink_d = bus.cfg_blink_half;
      pending_d   = 1'b1;
    end

    if (boundary) begin
      if (blink_cnt_q == blink_lim) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    if (apply) begin
      act_mode_d  = eff_mode;
      act_duty_d  = eff_duty;
      act_presc_d = eff_presc;
      act_blink_d = eff_blink;
      pending_d   = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      shd_mode_q  <= '0;
      shd_duty_q  <= '0;
      shd_presc_q <= '0;
      shd_blink_q <= '0;
      act_mode_q  <= '0;
      act_duty_q  <= '0;
      act_presc_q <= '0;
      act_blink_q <= '0;
      pending_q   <= 1'b0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      shd_mode_q  <= shd_mode_d;
      shd_duty_q  <= shd_duty_d;
      shd_presc_q <= shd_presc_d;
      shd_blink_q <= shd_blink_d;
      act_mode_q  <= act_mode_d;
      act_duty_q  <= act_duty_d;
      act_presc_q <= act_presc_d;
      act_blink_q <= act_blink_d;
      pending_q   <= pending_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  for (genvar gi = 0; gi < NLED; gi++) begin : g_led
    logic [1:0] mode_a;
    logic [7:0] duty_a;
    logic [7:0] level_q, level_d;
    br_state_e  state_q, state_d;
    logic       mode_change;

    assign mode_a      = act_mode_q[2*gi +: 2];
    assign duty_a      = act_duty_q[8*gi +: 8];
    assign mode_change = apply && (eff_mode[2*gi +: 2] != mode_a);

    // Breathe ramp: the turnaround step also moves the level, giving ..,d-1,d,d-1,..,1,0,1,..
    always_comb begin
      level_d = level_q;
      state_d = state_q;
      if (boundary) begin
        if (mode_change) begin
          level_d = 8'd0;
          state_d = BR_UP;
        end else if (mode_a == MODE_BREATHE) begin
          if (duty_a == 8'd0) begin
            level_d = 8'd0;
            state_d = BR_UP;
          end else if (state_q == BR_UP) begin
            if (level_q >= duty_a) begin
              state_d = BR_DOWN;
              level_d = level_q - 8'd1;
            end else begin
              level_d = level_q + 8'd1;
            end
          end else begin
            if (level_q == 8'd0) begin
              state_d = BR_UP;
              level_d = 8'd1;
            end else begin
              level_d = level_q - 8'd1;
            end
          end
        end
      end
    end

    always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
        level_q <= 8'd0;
        state_q <= BR_UP;
      end else begin
        level_q <= level_d;
        state_q <= state_d;
      end
    end

    assign led_d[gi] = (mode_a == MODE_OFF)   ? 1'b0 :
                       (mode_a == MODE_ON)    ? pwm_on(duty_a, pwm_cnt_q) :
                       (mode_a == MODE_BLINK) ? (phase_q && pwm_on(duty_a, pwm_cnt_q)) :
                                                pwm_on(level_q, pwm_cnt_q);

    if (gi == 0) begin : g_led0
      assign led0_level = level_q;
      assign led0_down  = (state_q == BR_DOWN);
    end
  end

  assign bus.led    = led_q;
  assign bus.status = {13'd0, pending_q, led0_level, led0_down, phase_q, pwm_cnt_q};

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: frame-level reference model compared
// every clock, a table of duty/mode vectors, and directed multi-frame sequences.
module tb_led_pwm_ctrl;
  localparam int NLED = 4;
  localparam int PW   = 16;

  logic clk = 1'b0;
  logic rst;

  led_pwm_ctrl_if #(.NLED(NLED), .PRESCALE_W(PW)) bus ();

  led_pwm_ctrl #(.NLED(NLED), .PRESCALE_W(PW)) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model (frame-level) ----------------
  int sh_mode[NLED], sh_duty[NLED], ac_mode[NLED], ac_duty[NLED];
  int sh_presc, sh_bh, ac_presc, ac_bh;
  int m_presc, m_pwm, m_frames;
  bit m_phase, m_pend, m_valid;
  int lvl[NLED];
  bit fall[NLED];
  logic [NLED-1:0] mled;

  function automatic bit lit(int x, int p);
    return (x == 255) || (p < x);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [7:0] l0, pw;
    l0 = 8'(lvl[0]);
    pw = 8'(m_pwm);
    return {13'd0, m_pend, l0, fall[0], m_phase, pw};
  endfunction

  task automatic model_clock();
    logic [NLED-1:0] nxt;
    bit tick, bnd;
    int lim;
    if (rst) begin
      for (int i = 0; i < NLED; i++) begin
        sh_mode[i] = 0; sh_duty[i] = 0; ac_mode[i] = 0; ac_duty[i] = 0;
        lvl[i] = 0; fall[i] = 0;
      end
      sh_presc = 0; sh_bh = 0; ac_presc = 0; ac_bh = 0;
      m_presc = 0; m_pwm = 0; m_frames = 0; m_phase = 0; m_pend = 0;
      mled = '0; m_valid = 1;
      return;
    end
    for (int i = 0; i < NLED; i++) begin
      case (ac_mode[i])
        0:       nxt[i] = 1'b0;
        1:       nxt[i] = lit(ac_duty[i], m_pwm);
        2:       nxt[i] = m_phase && lit(ac_duty[i], m_pwm);
        default: nxt[i] = lit(lvl[i], m_pwm);
      endcase
    end
    tick = (m_presc == ac_presc);
    bnd  = tick && (m_pwm == 255);
    if (bus.cfg_load) begin
      for (int i = 0; i < NLED; i++) begin
        sh_mode[i] = int'(bus.cfg_mode[2*i +: 2]);
        sh_duty[i] = int'(bus.cfg_duty[8*i +: 8]);
      end
      sh_presc = int'(bus.cfg_prescale);
      sh_bh    = int'(bus.cfg_blink_half);
      m_pend   = 1;
    end
    if (bnd) begin
      lim = ((ac_bh > 1) ? ac_bh : 1) - 1;
      if (m_frames == lim) begin m_phase = !m_phase; m_frames = 0; end
      else m_frames++;
      for (int i = 0; i < NLED; i++) begin
        if (m_pend && sh_mode[i] != ac_mode[i]) begin
          lvl[i] = 0; fall[i] = 0;
        end else if (ac_mode[i] == 3) begin
          if (ac_duty[i] == 0) begin lvl[i] = 0; fall[i] = 0; end
          else if (!fall[i]) begin
            if (lvl[i] >= ac_duty[i]) begin fall[i] = 1; lvl[i]--; end
            else lvl[i]++;
          end else if (lvl[i] == 0) begin fall[i] = 0; lvl[i] = 1; end
          else lvl[i]--;
        end
      end
      if (m_pend) begin
        for (int i = 0; i < NLED; i++) begin
          ac_mode[i] = sh_mode[i]; ac_duty[i] = sh_duty[i];
        end
        ac_presc = sh_presc; ac_bh = sh_bh; m_pend = 0;
      end
    end
    if (tick) begin m_presc = 0; m_pwm = (m_pwm + 1) % 256; end
    else m_presc++;
    mled = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
    if (m_valid) begin
      check("model_led", 32'(bus.led), 32'(mled));
      check("model_status", bus.status, exp_status());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_load = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic load(input int presc, input logic [7:0] modes,
                      input logic [31:0] duties, input int bh);
    bus.cfg_prescale   = PW'(presc);
    bus.cfg_mode       = modes;
    bus.cfg_duty       = duties;
    bus.cfg_blink_half = 16'(bh);
    bus.cfg_load       = 1'b1;
    cyc();
    bus.cfg_load       = 1'b0;
  endtask

  task automatic wait_applied(input int limit);
    for (int k = 0; k < limit && bus.status[18]; k++) cyc();
    check("apply_timeout", 32'(bus.status[18]), 32'd0);
  endtask

  function automatic logic [7:0] rnd_duty();
    case ($urandom_range(0, 5))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'(3);
      3: return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [7:0] duty;
    int         exp_high;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt, prev, run;
    int seq_lvl[7];
    bit seq_dn[7];
    logic [7:0] p;
    logic [31:0] duties;
    logic [7:0] modes;

    tbl[0] = '{2'b01, 8'd0,   0};
    tbl[1] = '{2'b01, 8'd1,   1};
    tbl[2] = '{2'b01, 8'd64,  64};
    tbl[3] = '{2'b01, 8'd254, 254};
    tbl[4] = '{2'b01, 8'd255, 256};
    tbl[5] = '{2'b00, 8'd255, 0};
    tbl[6] = '{2'b10, 8'd100, 100};
    tbl[7] = '{2'b11, 8'd5,   0};
    seq_lvl = '{1, 2, 3, 2, 1, 0, 1};
    seq_dn  = '{0, 0, 0, 1, 1, 1, 0};

    rst = 1'b1;
    bus.cfg_mode = '0; bus.cfg_duty = '0; bus.cfg_prescale = '0;
    bus.cfg_blink_half = '0; bus.cfg_load = 1'b0;
    m_valid = 0;

    do_reset();
    check("reset_led", 32'(bus.led), 32'd0);
    check("reset_status", bus.status, 32'd0);

    // Table: high clocks of led[0] in the first frame after the config applies.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      load(0, {6'b0, tbl[v].mode}, {24'b0, tbl[v].duty}, 0);
      wait_applied(600);
      check("tbl_led_before", 32'(bus.led[0]), 32'd0);
      cnt = 0;
      for (int k = 0; k < 256; k++) begin
        cyc();
        cnt += int'(bus.led[0]);
        if (k == 0) check("tbl_first", 32'(bus.led[0]), 32'(tbl[v].exp_high > 0));
      end
      check("tbl_high", 32'(cnt), 32'(tbl[v].exp_high));
      $display("vec %0d mode=%0d duty=%0d high=%0d", v, tbl[v].mode, tbl[v].duty, cnt);
    end

    // Prescale 3, full duty: constant on, pwm_cnt steps every 4 clocks.
    do_reset();
    load(3, 8'b0000_0001, 32'h0000_00FF, 0);
    wait_applied(600);
    cyc();
    cnt = 0;
    for (int k = 0; k < 100; k++) begin cyc(); cnt += int'(bus.led[0]); end
    check("presc_led_const", 32'(cnt), 32'd100);
    p = bus.status[7:0];
    for (int k = 0; k < 10 && bus.status[7:0] == p; k++) cyc();
    p = bus.status[7:0];
    run = 0;
    while (bus.status[7:0] == p && run < 10) begin cyc(); run++; end
    check("presc_step", 32'(run), 32'd4);
    $display("prescale3 run=%0d", run);

    // Blink on LED1 with half-period of two frames.
    do_reset();
    load(0, 8'b0000_1000, 32'h0000_FF00, 2);
    wait_applied(600);
    prev = int'(bus.led[1]);
    for (int k = 0; k < 1200 && int'(bus.led[1]) == prev; k++) cyc();
    for (int r = 0; r < 2; r++) begin
      prev = int'(bus.led[1]);
      run = 0;
      while (int'(bus.led[1]) == prev && run < 1200) begin cyc(); run++; end
      check("blink_period", 32'(run), 32'd512);
      check("blink_phase", 32'(bus.status[8]), 32'(prev == 0));
      $display("blink toggle after %0d clocks", run);
    end

    // Breathe on LED0, peak 3.
    do_reset();
    load(0, 8'b0000_0011, 32'h0000_0003, 0);
    wait_applied(600);
    check("breathe_start", 32'(bus.status[17:9]), 32'd0);
    for (int s = 0; s < 7; s++) begin
      for (int k = 0; k < 256; k++) cyc();
      check("breathe_level", 32'(bus.status[17:10]), 32'(seq_lvl[s]));
      check("breathe_dir", 32'(bus.status[9]), 32'(seq_dn[s]));
      $display("breathe boundary %0d level=%0d down=%0d", s, bus.status[17:10], bus.status[9]);
    end

    // Reset mid-frame discards pending config.
    do_reset();
    for (int k = 0; k < 10; k++) cyc();
    load(0, 8'b0000_0001, 32'h0000_00C8, 0);
    check("pend_set", 32'(bus.status[18]), 32'd1);
    for (int k = 0; k < 20; k++) cyc();
    do_reset();
    check("pend_discard", 32'(bus.status[18]), 32'd0);
    check("led_discard", 32'(bus.led), 32'd0);
    cnt = 0;
    for (int k = 0; k < 600; k++) begin cyc(); cnt += int'(bus.led[0]); end
    check("duty_never_applied", 32'(cnt), 32'd0);

    // Reset dominates a simultaneous load.
    rst = 1'b1;
    bus.cfg_load = 1'b1;
    cyc();
    rst = 1'b0;
    bus.cfg_load = 1'b0;
    check("rst_over_load", 32'(bus.status[18]), 32'd0);
    $display("reset/discard sequences done");

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 14000; k++) begin
      if ($urandom_range(0, 5999) == 0) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 899) == 0) begin
        for (int i = 0; i < NLED; i++) begin
          modes[2*i +: 2]  = 2'($urandom_range(0, 3));
          duties[8*i +: 8] = rnd_duty();
        end
        bus.cfg_mode       = modes;
        bus.cfg_duty       = duties;
        bus.cfg_prescale   = PW'($urandom_range(0, 2));
        bus.cfg_blink_half = 16'($urandom_range(0, 3));
        bus.cfg_load       = 1'b1;
        $display("random load at cycle %0d modes=%b duties=%h", k, modes, duties);
      end
      cyc();
      rst = 1'b0;
      bus.cfg_load = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter NLED, default 4, number of LED channels.
REQ-002 SHALL have parameter PRESCALE_W, default 16, prescaler compare width.
REQ-003 SHALL have port axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port axi_areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_mode  in  2*NLED  per-LED mode, 2 bits per LED (00 OFF, 01 ON, 10 BLINK, 11 BREATHE); LED i at bits [2i+1:2i].
REQ-006 SHALL have port cfg_duty  in  8*NLED  per-LED duty/peak level; LED i at bits [8i+7:8i].
REQ-007 SHALL have port cfg_prescale  in  PRESCALE_W  tick period minus one, in clocks.
REQ-008 SHALL have port cfg_blink_half  in  16  blink half-period, in PWM frames.
REQ-009 SHALL have port cfg_load  in  1  single-cycle pulse; register-write strobe from the register file.
REQ-010 SHALL have port led  out  NLED  registered LED drive.
REQ-011 SHALL have port status  out  32  readback word for the register file.

Function
REQ-012 SHALL capture all cfg_* inputs into a shadow set and set a pending flag on cfg_load=1.
REQ-013 SHALL copy shadow to active config and clear pending only at a frame boundary; cfg_load in the boundary cycle itself SHALL be applied at that boundary.
REQ-014 SHALL run a prescaler counting 0..active prescale, asserting tick and wrapping to 0 when equal; prescale=0 gives a tick every clock.
REQ-015 SHALL increment an 8-bit pwm_cnt on each tick, wrapping 255->0; frame boundary = tick with pwm_cnt==255.
REQ-016 SHALL define on(x) = (pwm_cnt < x), except x==255 gives constant 1.
REQ-017 OFF SHALL drive 0; ON SHALL drive on(duty).
REQ-018 BLINK: shared 16-bit frame counter and phase bit; at each boundary, when counter == max(blink_half,1)-1, SHALL toggle phase and clear counter, else increment; output = phase AND on(duty).
REQ-019 BREATHE: per-LED 8-bit level with FSM states UP/DOWN; at each boundary, UP increments level until level==duty then enters DOWN; DOWN decrements until 0 then enters UP; output = on(level).
REQ-020 BREATHE with duty=0 SHALL hold level 0, state UP.
REQ-021 Changing an LED's mode at a boundary SHALL reset that LED's level to 0 and state to UP.
REQ-022 led SHALL be registered: one clock after the pwm_cnt value it reflects.
REQ-023 status SHALL be [7:0] pwm_cnt, [8] blink phase, [9] LED0 breathe state (1=DOWN), [17:10] LED0 level, [18] pending, [31:19] zero.

Reset
REQ-024 axi_areset=1 SHALL clear prescaler, pwm_cnt, blink counter, phase, all levels, pending, shadow and active config (all OFF), and led to 0, on the next edge.
REQ-025 Reset SHALL dominate cfg_load in the same cycle; reset mid-frame SHALL discard pending config.

Verification
REQ-026 Reset, load prescale=0, mode0=ON, duty0=64 -> led[0] 0 until first boundary (clock 256), then 64 high / 192 low clocks per 256-clock frame.
REQ-027 prescale=3, mode0=ON, duty0=255 -> led[0] constant 1 after the first boundary; pwm_cnt in status advances every 4 clocks.
REQ-028 prescale=0, mode1=BLINK, duty1=255, blink_half=2 -> led[1] toggles every 512 clocks; status[8] tracks phase.
REQ-029 prescale=0, mode0=BREATHE, duty0=3 -> status[17:10] across successive boundaries 1,2,3,2,1,0,1; status[9] 1 while falling.
REQ-030 Load duty0=200 mid-frame, then reset before boundary -> status[18]=0, led=0, duty 200 never applied.
